// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle controller: state encoding, opcode/funct
// constants, ALU operation codes and datapath mux select encodings.
package cpu_defs;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ALU operations
  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluSlt = 4'd4;
  localparam logic [3:0] AluSll = 4'd5;
  localparam logic [3:0] AluSrl = 4'd6;

  // Extender field select
  localparam logic [1:0] ExtShamt  = 2'd0;
  localparam logic [1:0] ExtImm16  = 2'd1;
  localparam logic [1:0] ExtWord18 = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBFour = 2'd1;
  localparam logic [1:0] SrcBExt  = 2'd2;

  // Next-PC select
  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  // Register destination select
  localparam logic [1:0] DstRt = 2'd0;
  localparam logic [1:0] DstRd = 2'd1;

  typedef enum logic [3:0] {
    ClsRtype,
    ClsShift,
    ClsRbad,
    ClsImm,
    ClsLogicImm,
    ClsLoad,
    ClsStore,
    ClsBeq,
    ClsBne,
    ClsJump,
    ClsIllegal
  } instr_cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder: yields the instruction class and the ALU
// operation that class wants in EXEC.
module ctrl_decode
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_e cls,
  output logic [3:0] alu_op
);

  always_comb begin
    cls    = ClsIllegal;
    alu_op = AluAdd;
    case (opcode)
      OpRtype: begin
        cls = ClsRtype;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnSlt:   alu_op = AluSlt;
          FnSll: begin
            cls    = ClsShift;
            alu_op = AluSll;
          end
          FnSrl: begin
            cls    = ClsShift;
            alu_op = AluSrl;
          end
          default: cls = ClsRbad;
        endcase
      end
      OpJ:     cls = ClsJump;
      OpBeq: begin
        cls    = ClsBeq;
        alu_op = AluSub;
      end
      OpBne: begin
        cls    = ClsBne;
        alu_op = AluSub;
      end
      OpAddi, OpAddiu: cls = ClsImm;
      OpAndi: begin
        cls    = ClsLogicImm;
        alu_op = AluAnd;
      end
      OpOri: begin
        cls    = ClsLogicImm;
        alu_op = AluOr;
      end
      OpLw:    cls = ClsLoad;
      OpSw:    cls = ClsStore;
      default: cls = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// bounded wait on mem_ready in FETCH and MEM.
module multicycle_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] ext_sel,
  output logic       sign_ext,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  instr_cls_e      cls;
  logic [3:0]      dec_alu_op;
  logic            waiting, expired, taken;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls),
    .alu_op (dec_alu_op)
  );

  assign state   = state_q;
  assign waiting = (state_q == StFetch) || (state_q == StMem);
  assign expired = waiting && !mem_ready && (wait_q == CntW'(MEM_TIMEOUT));
  assign taken   = ((cls == ClsBeq) && zero) || ((cls == ClsBne) && !zero);

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    ext_sel    = ExtShamt;
    sign_ext   = 1'b0;
    alu_src_b  = SrcBReg;
    alu_op     = AluAdd;
    reg_dst    = DstRt;
    pc_src     = PcAlu;
    illegal    = 1'b0;
    timeout    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read  = !expired;
        alu_src_b = SrcBFour;
        alu_op    = AluAdd;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PcAlu;
          state_d  = StDecode;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      StDecode: begin
        // ALU speculatively forms the branch target PC + (offset << 2)
        ext_sel   = ExtWord18;
        sign_ext  = 1'b1;
        alu_src_b = SrcBExt;
        alu_op    = AluAdd;
        if (cls == ClsJump) begin
          pc_write = 1'b1;
          pc_src   = PcJump;
          state_d  = StFetch;
        end else if (cls == ClsIllegal) begin
          illegal = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls)
          ClsRtype: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBReg;
            alu_op    = dec_alu_op;
            state_d   = StWb;
          end
          ClsShift: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBExt;
            ext_sel   = ExtShamt;
            alu_op    = dec_alu_op;
            state_d   = StWb;
          end
          ClsImm, ClsLoad, ClsStore: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBExt;
            ext_sel   = ExtImm16;
            sign_ext  = 1'b1;
            alu_op    = AluAdd;
            state_d   = (cls == ClsImm) ? StWb : StMem;
          end
          ClsLogicImm: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBExt;
            ext_sel   = ExtImm16;
            alu_op    = dec_alu_op;
            state_d   = StWb;
          end
          ClsBeq, ClsBne: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBReg;
            alu_op    = AluSub;
            pc_write  = taken;
            pc_src    = taken ? PcBranch : PcAlu;
            state_d   = StFetch;
          end
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMem: begin
        mem_read  = (cls == ClsLoad) && !expired;
        mem_write = (cls == ClsStore) && !expired;
        if (mem_ready) begin
          state_d = (cls == ClsLoad) ? StWb : StFetch;
        end else if (expired) begin
          timeout = 1'b1;
          state_d = StFetch;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = ((cls == ClsRtype) || (cls == ClsShift)) ? DstRd : DstRt;
        mem_to_reg = (cls == ClsLoad);
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // A memory response arriving while reset is held belongs to an abandoned access
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      timeout   = 1'b0;
    end
  end

  always_comb begin
    if ((state_d != state_q) || expired || !waiting) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle stimulus and expected outputs are
// queued together and checked at the falling edge.
module tb_multicycle_ctrl;
  import cpu_defs::*;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] ext_sel;
    logic       sign_ext;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic       illegal;
    logic       timeout;
  } outs_t;

  typedef struct {
    logic [95:0] tag;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    outs_t       exp;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a;
  logic [1:0] ext_sel, alu_src_b, reg_dst, pc_src;
  logic       sign_ext, illegal, timeout;
  logic [3:0] alu_op;
  logic [2:0] state;

  outs_t obs;
  step_t sb_q[$];
  int    passed = 0;
  int    total = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .ext_sel    (ext_sel),
    .sign_ext   (sign_ext),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .pc_src     (pc_src),
    .state      (state),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
                alu_src_a, ext_sel, sign_ext, alu_src_b, alu_op, reg_dst, pc_src,
                illegal, timeout};

  function automatic outs_t f_fetch(input logic rdy);
    outs_t o;
    o = '0;
    o.state = 3'd0;
    o.mem_read = 1'b1;
    o.alu_src_b = 2'd1;
    o.alu_op = AluAdd;
    o.ir_write = rdy;
    o.pc_write = rdy;
    return o;
  endfunction

  function automatic outs_t f_decode();
    outs_t o;
    o = '0;
    o.state = 3'd1;
    o.ext_sel = 2'd2;
    o.sign_ext = 1'b1;
    o.alu_src_b = 2'd2;
    o.alu_op = AluAdd;
    return o;
  endfunction

  function automatic outs_t f_exec(input logic [1:0] srcb, input logic [1:0] ext,
                                   input logic sx, input logic [3:0] op);
    outs_t o;
    o = '0;
    o.state = 3'd2;
    o.alu_src_a = 1'b1;
    o.alu_src_b = srcb;
    o.ext_sel = ext;
    o.sign_ext = sx;
    o.alu_op = op;
    return o;
  endfunction

  function automatic outs_t f_mem(input logic rd, input logic wr);
    outs_t o;
    o = '0;
    o.state = 3'd3;
    o.mem_read = rd;
    o.mem_write = wr;
    return o;
  endfunction

  function automatic outs_t f_wb(input logic [1:0] dst, input logic m2r);
    outs_t o;
    o = '0;
    o.state = 3'd4;
    o.reg_write = 1'b1;
    o.reg_dst = dst;
    o.mem_to_reg = m2r;
    return o;
  endfunction

  task automatic push(input logic [95:0] tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input outs_t e);
    step_t s;
    s.tag = tag;
    s.opcode = op;
    s.funct = fn;
    s.zero = z;
    s.rdy = rdy;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  // Drives each queued cycle right after the rising edge and checks at the falling edge
  task automatic run_all();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      opcode = s.opcode;
      funct = s.funct;
      zero = s.zero;
      mem_ready = s.rdy;
      @(negedge clk);
      total++;
      assert (obs === s.exp) passed++;
      else $error("FAIL %0s: got %h exp %h (state got %0d exp %0d)",
                  s.tag, obs, s.exp, obs.state, s.exp.state);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input logic [95:0] tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %0s: got %0h exp %0h", tag, got, want);
  endtask

  initial begin
    outs_t e;
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b1;

    // Reset state with mem_ready high: only the fetch request may show
    #3;
    chk1("rst_outs", 32'(obs), 32'(f_fetch(1'b0)));
    chk1("rst_pcw", 32'(pc_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add, mem_ready held high throughout: 0,1,2,4,0
    push("add_f", OpRtype, FnAdd, 1'b0, 1'b1, f_fetch(1'b1));
    push("add_d", OpRtype, FnAdd, 1'b0, 1'b1, f_decode());
    push("add_e", OpRtype, FnAdd, 1'b0, 1'b1, f_exec(2'd0, 2'd0, 1'b0, AluAdd));
    push("add_w", OpRtype, FnAdd, 1'b0, 1'b1, f_wb(2'd1, 1'b0));
    // sub, zero-wait
    push("sub_f", OpRtype, FnSub, 1'b0, 1'b1, f_fetch(1'b1));
    push("sub_d", OpRtype, FnSub, 1'b0, 1'b0, f_decode());
    push("sub_e", OpRtype, FnSub, 1'b0, 1'b0, f_exec(2'd0, 2'd0, 1'b0, AluSub));
    push("sub_w", OpRtype, FnSub, 1'b0, 1'b0, f_wb(2'd1, 1'b0));
    run_all();

    // lw with three wait cycles in MEM
    push("lw_f", OpLw, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("lw_d", OpLw, 6'h00, 1'b0, 1'b0, f_decode());
    push("lw_e", OpLw, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b1, AluAdd));
    for (int i = 0; i < 3; i++) push("lw_mwait", OpLw, 6'h00, 1'b0, 1'b0, f_mem(1'b1, 1'b0));
    push("lw_mdone", OpLw, 6'h00, 1'b0, 1'b1, f_mem(1'b1, 1'b0));
    push("lw_w", OpLw, 6'h00, 1'b0, 1'b0, f_wb(2'd0, 1'b1));
    // sw zero-wait: 4 cycles
    push("sw_f", OpSw, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("sw_d", OpSw, 6'h00, 1'b0, 1'b0, f_decode());
    push("sw_e", OpSw, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b1, AluAdd));
    push("sw_m", OpSw, 6'h00, 1'b0, 1'b1, f_mem(1'b0, 1'b1));
    run_all();

    // beq taken then not taken, bne taken
    push("beq1_f", OpBeq, 6'h00, 1'b1, 1'b1, f_fetch(1'b1));
    push("beq1_d", OpBeq, 6'h00, 1'b1, 1'b0, f_decode());
    e = f_exec(2'd0, 2'd0, 1'b0, AluSub);
    e.pc_write = 1'b1;
    e.pc_src = 2'd1;
    push("beq1_e", OpBeq, 6'h00, 1'b1, 1'b0, e);
    push("beq0_f", OpBeq, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("beq0_d", OpBeq, 6'h00, 1'b0, 1'b0, f_decode());
    push("beq0_e", OpBeq, 6'h00, 1'b0, 1'b0, f_exec(2'd0, 2'd0, 1'b0, AluSub));
    push("bne_f", OpBne, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("bne_d", OpBne, 6'h00, 1'b0, 1'b0, f_decode());
    push("bne_e", OpBne, 6'h00, 1'b0, 1'b0, e);
    run_all();

    // ori, addiu, sll, srl
    push("ori_f", OpOri, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("ori_d", OpOri, 6'h00, 1'b0, 1'b0, f_decode());
    push("ori_e", OpOri, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b0, AluOr));
    push("ori_w", OpOri, 6'h00, 1'b0, 1'b0, f_wb(2'd0, 1'b0));
    push("addiu_f", OpAddiu, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("addiu_d", OpAddiu, 6'h00, 1'b0, 1'b0, f_decode());
    push("addiu_e", OpAddiu, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b1, AluAdd));
    push("addiu_w", OpAddiu, 6'h00, 1'b0, 1'b0, f_wb(2'd0, 1'b0));
    push("sll_f", OpRtype, FnSll, 1'b0, 1'b1, f_fetch(1'b1));
    push("sll_d", OpRtype, FnSll, 1'b0, 1'b0, f_decode());
    push("sll_e", OpRtype, FnSll, 1'b0, 1'b0, f_exec(2'd2, 2'd0, 1'b0, AluSll));
    push("sll_w", OpRtype, FnSll, 1'b0, 1'b0, f_wb(2'd1, 1'b0));
    push("srl_f", OpRtype, FnSrl, 1'b0, 1'b1, f_fetch(1'b1));
    push("srl_d", OpRtype, FnSrl, 1'b0, 1'b0, f_decode());
    push("srl_e", OpRtype, FnSrl, 1'b0, 1'b0, f_exec(2'd2, 2'd0, 1'b0, AluSrl));
    push("srl_w", OpRtype, FnSrl, 1'b0, 1'b0, f_wb(2'd1, 1'b0));
    run_all();

    // j in 2 cycles, illegal opcode, illegal funct
    push("j_f", OpJ, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    e = f_decode();
    e.pc_write = 1'b1;
    e.pc_src = 2'd2;
    push("j_d", OpJ, 6'h00, 1'b0, 1'b0, e);
    push("ill_f", 6'h3F, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    e = f_decode();
    e.illegal = 1'b1;
    push("ill_d", 6'h3F, 6'h00, 1'b0, 1'b0, e);
    push("illfn_f", OpRtype, 6'h3F, 1'b0, 1'b1, f_fetch(1'b1));
    push("illfn_d", OpRtype, 6'h3F, 1'b0, 1'b0, f_decode());
    e = '0;
    e.state = 3'd2;
    e.illegal = 1'b1;
    push("illfn_e", OpRtype, 6'h3F, 1'b0, 1'b0, e);
    run_all();

    // FETCH timeout on the 16th cycle without mem_ready; counter restarts after
    for (int i = 0; i < 15; i++) push("fto_wait", OpJ, 6'h00, 1'b0, 1'b0, f_fetch(1'b0));
    e = f_fetch(1'b0);
    e.mem_read = 1'b0;
    e.timeout = 1'b1;
    push("fto_pulse", OpJ, 6'h00, 1'b0, 1'b0, e);
    push("fto_after", OpJ, 6'h00, 1'b0, 1'b0, f_fetch(1'b0));
    push("fto_f", OpJ, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    e = f_decode();
    e.pc_write = 1'b1;
    e.pc_src = 2'd2;
    push("fto_j_d", OpJ, 6'h00, 1'b0, 1'b0, e);
    run_all();

    // MEM timeout on sw: request drops, back to FETCH
    push("mto_f", OpSw, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("mto_d", OpSw, 6'h00, 1'b0, 1'b0, f_decode());
    push("mto_e", OpSw, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b1, AluAdd));
    for (int i = 0; i < 15; i++) push("mto_wait", OpSw, 6'h00, 1'b0, 1'b0, f_mem(1'b0, 1'b1));
    e = f_mem(1'b0, 1'b0);
    e.timeout = 1'b1;
    push("mto_pulse", OpSw, 6'h00, 1'b0, 1'b0, e);
    push("mto_next", OpSw, 6'h00, 1'b0, 1'b0, f_fetch(1'b0));
    run_all();

    // Reset during sw MEM wait takes effect without a clock edge
    push("rsw_f", OpSw, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("rsw_d", OpSw, 6'h00, 1'b0, 1'b0, f_decode());
    push("rsw_e", OpSw, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b1, AluAdd));
    push("rsw_m", OpSw, 6'h00, 1'b0, 1'b0, f_mem(1'b0, 1'b1));
    run_all();
    chk1("rsw_pre_st", 32'(state), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk1("rsw_state", 32'(state), 32'd0);
    chk1("rsw_memwr", 32'(mem_write), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk1("rsw_pcw", 32'(pc_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("post_f", OpAddi, 6'h00, 1'b0, 1'b1, f_fetch(1'b1));
    push("post_d", OpAddi, 6'h00, 1'b0, 1'b0, f_decode());
    push("post_e", OpAddi, 6'h00, 1'b0, 1'b0, f_exec(2'd2, 2'd1, 1'b1, AluAdd));
    push("post_w", OpAddi, 6'h00, 1'b0, 1'b0, f_wb(2'd0, 1'b0));
    push("post_f2", OpAddi, 6'h00, 1'b0, 1'b0, f_fetch(1'b0));
    run_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready per access.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports opcode in 6 and funct in 6: IR fields, valid from DECODE on.
REQ-005 SHALL have ports zero in 1 (ALU zero flag) and mem_ready in 1 (memory access complete this cycle).
REQ-006 SHALL have outputs pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, each 1 bit.
REQ-007 SHALL have outputs ext_sel out 2 (0=5-bit shamt, 1=16-bit imm, 2=18-bit word offset) and sign_ext out 1 (extender mode).
REQ-008 SHALL have outputs alu_src_b out 2 (0=reg, 1=const 4, 2=ext), alu_op out 4, reg_dst out 2 (0=rt, 1=rd), pc_src out 2 (0=ALU, 1=branch target, 2=jump).
REQ-009 SHALL have outputs state out 3 (current state), illegal out 1 (1-cycle pulse), timeout out 1 (1-cycle pulse).

Function
REQ-010 SHALL implement states FETCH, DECODE, EXEC, MEM, WB; encoding FETCH=0..WB=4.
REQ-011 FETCH: mem_read=1, alu_src_a=0 (PC), alu_src_b=1, alu_op=ADD; on mem_ready pulse ir_write=1, pc_write=1, pc_src=0, go DECODE; else hold.
REQ-012 DECODE: ext_sel=2, sign_ext=1, alu computes PC+offset (branch target); j: pc_write=1, pc_src=2, go FETCH; illegal opcode: illegal=1, go FETCH; else go EXEC.
REQ-013 EXEC, R-type (add, sub, and, or, slt, sll, srl): alu_src_a=1, alu_src_b=0 (sll/srl: alu_src_b=2, ext_sel=0, sign_ext=0); alu_op from funct; go WB; unknown funct = illegal, go FETCH.
REQ-014 EXEC, addi/lw/sw: ext_sel=1, sign_ext=1, alu_src_b=2, alu_op=ADD; addiu same with sign_ext=1; andi/ori: sign_ext=0, alu_op=AND/OR.
REQ-015 EXEC, beq/bne: alu_op=SUB, alu_src_b=0; pc_write=1 and pc_src=1 iff (beq and zero) or (bne and !zero); go FETCH.
REQ-016 EXEC next state: lw/sw go MEM; immediate ALU ops go WB.
REQ-017 MEM: lw mem_read=1, sw mem_write=1, held until mem_ready; sw goes FETCH, lw goes WB.
REQ-018 WB: reg_write=1 exactly one cycle; reg_dst=1 for R-type else 0; mem_to_reg=1 only for lw; go FETCH.
REQ-019 Wait counter SHALL clear on entering FETCH/MEM; if it reaches MEM_TIMEOUT without mem_ready, pulse timeout, deassert request, go FETCH without pc_write.
REQ-020 Latency with zero-wait memory: R-type/imm 4 cycles, lw 5, sw 4, beq/bne 3, j 2.
REQ-021 All control outputs SHALL be 0 in any state where not explicitly asserted; no output glitch-dependent on inputs other than mem_ready, zero, opcode, funct.
REQ-022 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-023 rst=1 SHALL force state=FETCH, wait counter=0, illegal=0, timeout=0 immediately, regardless of clk.
REQ-024 Reset asserted mid-access (MEM or FETCH wait) SHALL abandon the access; no pc_write/reg_write/mem_write on first post-reset cycle except FETCH mem_read.

Structure
REQ-025 State encoding, opcode/funct constants, alu_op codes, ext_sel/pc_src encodings SHALL live in shared package cpu_defs.
REQ-026 Opcode/funct decode SHALL be a sub-module ctrl_decode (combinational, outputs instruction class and alu_op).

Verification
REQ-027 add (opcode 0, funct 0x20), mem_ready=1 always -> states 0,1,2,4,0; reg_write=1 only in cycle 4, reg_dst=1.
REQ-028 lw (0x23), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, ext_sel=1 sign_ext=1 in EXEC, mem_to_reg=1 in WB.
REQ-029 beq (0x04) with zero=1 -> pc_write=1, pc_src=1 in EXEC; with zero=0 -> pc_write=0; both return FETCH after 3 cycles.
REQ-030 ori (0x0D) -> sign_ext=0, ext_sel=1 in EXEC; sll -> ext_sel=0 in EXEC.
REQ-031 opcode 0x3F -> illegal pulses once in DECODE, next state FETCH; mem_ready stuck 0 in FETCH for 16 cycles -> timeout pulse, no pc_write.
REQ-032 rst asserted during MEM of sw -> state=0 asynchronously, mem_write=0 same cycle.
